// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction-fetch
// path and the load/store data path. Data accesses win by default. A streak counter
// bounds how many data grants in a row can pass a waiting fetch. Grants are
// combinational in the request cycle. Read-return flags are registered so each
// requester sees rvalid in the cycle after its read grant, which is when the RAM
// presents the data on mem_q.

module mem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned MAX_DATA_BURST = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  // Instruction-fetch port (read only)
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,

  // Load/store data port
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,

  // Shared RAM port
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,

  output logic                  busy
);

  // Wide enough to hold 0..MAX_DATA_BURST inclusive.
  localparam int unsigned         StreakW   = $clog2(MAX_DATA_BURST + 1);
  localparam logic [StreakW-1:0]  StreakMax = StreakW'(MAX_DATA_BURST);
  localparam logic [StreakW-1:0]  StreakOne = StreakW'(1);

  // Consecutive data grants issued while fetch was also requesting.
  logic [StreakW-1:0] streak_q, streak_d;

  // Read-return tracking: set in the cycle after a read grant on that port.
  logic if_pend_q, if_pend_d;
  logic dm_pend_q, dm_pend_d;

  // Arbitration: one grant per cycle, data first unless its streak is used up.
  // Grants are held low during reset so nothing reaches the RAM.
  always_comb begin
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    streak_d = streak_q;
    if (rst) begin
      case ({if_req, dm_req})
        2'b10: begin
          if_gnt   = 1'b1;
          streak_d = '0;
        end
        2'b01: begin
          // No competing fetch, so the streak does not advance.
          dm_gnt = 1'b1;
        end
        2'b11: begin
          if (streak_q < StreakMax) begin
            dm_gnt   = 1'b1;
            streak_d = streak_q + StreakOne;
          end else begin
            if_gnt   = 1'b1;
            streak_d = '0;
          end
        end
        default: begin
          streak_d = streak_q;
        end
      endcase
    end
  end

  // RAM drive: granted port steers the address; write data is always the data port's.
  always_comb begin
    mem_address = '0;
    if (dm_gnt) begin
      mem_address = dm_addr;
    end else if (if_gnt) begin
      mem_address = if_addr;
    end
    mem_wren = dm_gnt & dm_we;
    mem_data = dm_wdata;
    busy     = if_gnt | dm_gnt;
  end

  // Next-state for the read-return flags; writes never return data.
  always_comb begin
    if_pend_d = if_gnt;
    dm_pend_d = dm_gnt & ~dm_we;
  end

  // State registers; an asynchronous reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_q  <= '0;
      if_pend_q <= 1'b0;
      dm_pend_q <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      if_pend_q <= if_pend_d;
      dm_pend_q <= dm_pend_d;
    end
  end

  // Read returns: RAM output is shared, rvalid tells each port when it is theirs.
  always_comb begin
    if_rvalid = if_pend_q;
    dm_rvalid = dm_pend_q;
    if_rdata  = mem_q;
    dm_rdata  = mem_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vectors with hand-computed grants, plus a
// scoreboard of expected read returns checked by an independent monitor.

module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t if_sb[$];
  exp_t dm_sb[$];

  logic [DW-1:0] ram [64];

  mem_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .MAX_DATA_BURST (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_gnt      (dm_gnt),
    .dm_rvalid   (dm_rvalid),
    .dm_rdata    (dm_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM with one-cycle read latency; contents ram[i] = C0DE_00ii, ram[5] special.
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hC0DE_0000 | i;
    ram[5] = 32'h1234_5678;
    mem_q  = '0;
    forever begin
      @(posedge clk);
      if (mem_wren) ram[mem_address] <= mem_data;
      mem_q <= ram[mem_address];
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard when a return is due, flags any unrequested rvalid.
  initial begin
    forever begin
      @(negedge clk);
      if (if_sb.size() > 0 && if_sb[0].due == cyc) begin
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== if_sb[0].data) begin
          errors++;
          $display("FAIL if_read: rvalid=%b rdata=%h, expected rvalid=1 rdata=%h (cycle %0d)",
                   if_rvalid, if_rdata, if_sb[0].data, cyc);
        end
        void'(if_sb.pop_front());
      end else if (if_rvalid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL if_unexpected_rvalid: rvalid=%b, expected 0 (cycle %0d)", if_rvalid, cyc);
      end
      if (dm_sb.size() > 0 && dm_sb[0].due == cyc) begin
        checks++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== dm_sb[0].data) begin
          errors++;
          $display("FAIL dm_read: rvalid=%b rdata=%h, expected rvalid=1 rdata=%h (cycle %0d)",
                   dm_rvalid, dm_rdata, dm_sb[0].data, cyc);
        end
        void'(dm_sb.pop_front());
      end else if (dm_rvalid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL dm_unexpected_rvalid: rvalid=%b, expected 0 (cycle %0d)", dm_rvalid, cyc);
      end
    end
  end

  // One cycle of stimulus: drive, check combinational grant/RAM outputs mid-cycle,
  // and queue the expected read return (unless a reset will kill it).
  task automatic step(input string tag, input logic r,
                      input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dwe, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd,
                      input logic eif, input logic edm, input logic [DW-1:0] ed,
                      input logic nopush);
    logic [AW-1:0] eaddr;
    exp_t          e;
    rst      = r;
    if_req   = ir;
    if_addr  = ia;
    dm_req   = dr;
    dm_we    = dwe;
    dm_addr  = da;
    dm_wdata = dwd;
    @(negedge clk);
    eaddr = edm ? da : (eif ? ia : '0);
    chk({tag, " if_gnt"},   DW'(if_gnt),      DW'(eif));
    chk({tag, " dm_gnt"},   DW'(dm_gnt),      DW'(edm));
    chk({tag, " busy"},     DW'(busy),        DW'(eif | edm));
    chk({tag, " mem_addr"}, DW'(mem_address), DW'(eaddr));
    chk({tag, " mem_wren"}, DW'(mem_wren),    DW'(edm & dwe));
    chk({tag, " mem_data"}, mem_data,         dwd);
    e.due  = cyc + 1;
    e.data = ed;
    if (!nopush) begin
      if (eif) if_sb.push_back(e);
      if (edm && !dwe) dm_sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    @(posedge clk);
    #1;
    //    tag          rst ir ia  dr we da  wdata          eif edm exp_data       nopush
    // Reset holds everything off even with both requests up.
    step("rst0",       0,  1, 1,  1, 0, 2,  32'h0,         0,  0,  32'h0,         0);
    step("rst1",       0,  1, 1,  1, 1, 2,  32'h1111_1111, 0,  0,  32'h0,         0);
    // Fairness after release: dm, dm, if, dm, dm, if.
    step("fair0",      1,  1, 1,  1, 0, 2,  32'h0,         0,  1,  32'hC0DE_0002, 0);
    step("fair1",      1,  1, 1,  1, 0, 2,  32'h0,         0,  1,  32'hC0DE_0002, 0);
    step("fair2",      1,  1, 1,  1, 0, 2,  32'h0,         1,  0,  32'hC0DE_0001, 0);
    step("fair3",      1,  1, 3,  1, 0, 4,  32'h0,         0,  1,  32'hC0DE_0004, 0);
    step("fair4",      1,  1, 3,  1, 0, 6,  32'h0,         0,  1,  32'hC0DE_0006, 0);
    step("fair5",      1,  1, 3,  1, 0, 8,  32'h0,         1,  0,  32'hC0DE_0003, 0);
    // Fetch-only read of the preloaded word.
    step("fetch5",     1,  1, 5,  0, 0, 0,  32'h0,         1,  0,  32'h1234_5678, 0);
    // Write then read the same address on consecutive cycles.
    step("wr3",        1,  0, 0,  1, 1, 3,  32'hDEAD_BEEF, 0,  1,  32'h0,         0);
    step("rd3",        1,  0, 0,  1, 0, 3,  32'h0,         0,  1,  32'hDEAD_BEEF, 0);
    step("idle0",      1,  0, 0,  0, 0, 0,  32'h0,         0,  0,  32'h0,         0);
    // Data-only grants do not advance the streak.
    step("donly0",     1,  0, 0,  1, 0, 10, 32'h0,         0,  1,  32'hC0DE_000A, 0);
    step("donly1",     1,  0, 0,  1, 0, 11, 32'h0,         0,  1,  32'hC0DE_000B, 0);
    step("donly2",     1,  0, 0,  1, 0, 12, 32'h0,         0,  1,  32'hC0DE_000C, 0);
    step("donly3",     1,  0, 0,  1, 0, 13, 32'h0,         0,  1,  32'hC0DE_000D, 0);
    step("both0",      1,  1, 20, 1, 0, 14, 32'h0,         0,  1,  32'hC0DE_000E, 0);
    step("both1",      1,  1, 20, 1, 0, 15, 32'h0,         0,  1,  32'hC0DE_000F, 0);
    step("both2",      1,  1, 20, 1, 0, 15, 32'h0,         1,  0,  32'hC0DE_0014, 0);
    // Data write wins over fetch, then fetch reads the freshly written word.
    step("wr20",       1,  1, 21, 1, 1, 20, 32'hFACE_0020, 0,  1,  32'h0,         0);
    step("rd20",       1,  1, 20, 0, 0, 0,  32'h0,         1,  0,  32'hFACE_0020, 0);
    // dm_we without dm_req must not write.
    step("noreq_we",   1,  0, 0,  0, 1, 9,  32'h5555_AAAA, 0,  0,  32'h0,         0);
    // Reset during an outstanding read suppresses its rvalid.
    step("rd7_killed", 1,  0, 0,  1, 0, 7,  32'h0,         0,  1,  32'h0,         1);
    step("midrst",     0,  0, 0,  0, 0, 0,  32'h0,         0,  0,  32'h0,         0);
    step("post0",      1,  0, 0,  0, 0, 0,  32'h0,         0,  0,  32'h0,         0);
    step("post1",      1,  0, 0,  0, 0, 0,  32'h0,         0,  0,  32'h0,         0);
    step("post2",      1,  0, 0,  0, 0, 0,  32'h0,         0,  0,  32'h0,         0);
    chk("sb_drained", DW'(if_sb.size() + dm_sb.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one synchronous RAM (one-cycle read latency, single address/data/wren port) between the CPU instruction-fetch path and the load/store data path. It sits between the MIPS datapath and the shared RAM, letting a single memory serve both program and data. Data accesses have priority, with a bounded-streak rule so fetch is never starved. Read-return tracking and the fairness counter are registered; grant decisions are combinational within the request cycle.

## Interface
- DATA_WIDTH, 32, width of memory words and data ports
- ADDR_WIDTH, 6, RAM address width
- MAX_DATA_BURST, 2, max consecutive data grants while fetch is waiting (≥1)

- clk  in  1  system clock; all registers on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_WIDTH  fetch word address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  DATA_WIDTH  fetch read data
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_gnt  out  1  data granted this cycle (combinational)
- dm_rvalid  out  1  dm_rdata valid (registered)
- dm_rdata  out  DATA_WIDTH  data read data
- mem_address  out  ADDR_WIDTH  to RAM address
- mem_data  out  DATA_WIDTH  to RAM write data
- mem_wren  out  1  to RAM write enable
- mem_q  in  DATA_WIDTH  from RAM read data
- busy  out  1  a grant is issued this cycle

## Operation
- Registered state: streak (counter, 0..MAX_DATA_BURST), if_pend_r, dm_pend_r (read-return flags).
- At most one grant per cycle. Arbitration:
  - only if_req: if_gnt=1; streak←0.
  - only dm_req: dm_gnt=1; streak unchanged.
  - both: if streak < MAX_DATA_BURST then dm_gnt=1, streak←streak+1; else if_gnt=1, streak←0.
  - neither: no grant; streak unchanged.
- Grant outputs are 0 while rst=0.
- Memory drive:
  - mem_address = dm_addr if dm_gnt, if_addr if if_gnt, else 0.
  - mem_wren = dm_gnt & dm_we.
  - mem_data = dm_wdata at all times.
- Read tracking: if_pend_r←if_gnt; dm_pend_r←dm_gnt & ~dm_we.
- if_rvalid = if_pend_r; dm_rvalid = dm_pend_r.
- if_rdata = dm_rdata = mem_q (pass-through). Data is only defined while the matching rvalid=1.
- Writes never produce rvalid.
- busy = if_gnt | dm_gnt.
- Requester contract: hold req/addr/we/wdata stable until gnt. A new request may be issued in the cycle after gnt, concurrently with rvalid, giving back-to-back throughput of one access per cycle.

## Timing
- Reset (rst=0, asynchronous): streak=0, if_pend_r=dm_pend_r=0, so if_rvalid=dm_rvalid=0. if_gnt=dm_gnt=0, mem_wren=0, mem_address=0, busy=0.
- Reset during an outstanding read: the rvalid for that read is suppressed and never appears.
- Read latency: gnt in cycle N; RAM captures address at edge ending N; rvalid=1 and rdata=mem_q in cycle N+1.
- Write: committed at the edge ending the grant cycle. A read of the same address granted in the next cycle returns the new data.
- Back-to-back reads on different ports: grants in N and N+1 give rvalids in N+1 and N+2, with no overlap.
- Worst-case fetch wait with continuous dm_req: MAX_DATA_BURST cycles, then granted.
- streak saturates at MAX_DATA_BURST and never wraps.

## Test plan
- Reset: rst=0 with both reqs high → all grants, rvalids and mem_wren stay 0. After rst=1, the first cycle grants dm; streak=1.
- Fetch-only read: RAM[5]=0x1234_5678; if_req, if_addr=5 in cycle N → if_gnt=1 and mem_address=5 in N; if_rvalid=1 and if_rdata=0x12345678 in N+1.
- Write then read: dm write addr 3, data 0xDEADBEEF in N; dm read addr 3 in N+1 → mem_wren=1 only in N; dm_rvalid=1 with 0xDEADBEEF in N+2; no rvalid in N+1.
- Fairness: both reqs held high for 6 cycles, MAX_DATA_BURST=2 → grant sequence dm, dm, if, dm, dm, if.
- Data-only streak: 4 dm-only grants, then both reqs → dm granted first; streak did not count while no fetch was pending.
- Reset mid-read: dm read granted in N; rst=0 during N+1 → dm_rvalid is 0 in N+1 and stays 0 after release.
